// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter.
// State encoding, requester indices and a one-hot helper.
package rr_mux_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [1:0] REQ_A = 2'd0;
  localparam logic [1:0] REQ_B = 2'd1;
  localparam logic [1:0] REQ_C = 2'd2;
  localparam logic [1:0] REQ_D = 2'd3;

  // After reset requester A is searched first.
  localparam logic [1:0] LAST_RESET = REQ_D;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// Four-input data mux steered by the arbiter select.
// Purely combinational.
module mux_4to1
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [1:0]   sel,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  input  logic [N-1:0] d,
  output logic [N-1:0] y
);

  // Route the selected requester bus to the output.
  always_comb begin
    y = a;
    unique case (sel)
      REQ_A: y = a;
      REQ_B: y = b;
      REQ_C: y = c;
      REQ_D: y = d;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin priority rotator.
// Search starts one past last_winner and wraps.
module rr_pick4
  import rr_mux_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last_winner,
  output logic       any,
  output logic [1:0] winner
);

  logic [1:0] idx;

  assign any = |req;

  // Walk from farthest to nearest so the nearest hit is kept.
  always_comb begin
    winner = last_winner;
    idx    = last_winner;
    for (int i = 4; i >= 1; i--) begin
      idx = last_winner + 2'(i);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-way round-robin arbiter owning a shared N-bit datapath.
// Optional burst limit: define RR_ARB_BURST_LIMIT_EN.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [N-1:0] data_a,
  input  logic [N-1:0] data_b,
  input  logic [N-1:0] data_c,
  input  logic [N-1:0] data_d,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic [N-1:0] out_data,
  output logic         out_valid
);

  state_t     state;
  logic [1:0] last_winner;
  logic       any;
  logic [1:0] winner;
  logic       owner_req;
  logic       rearb;

  assign owner_req = req[sel];
  assign out_valid = (state == ST_GRANT) & owner_req;

  rr_pick4 u_pick (
    .req         (req),
    .last_winner (last_winner),
    .any         (any),
    .winner      (winner)
  );

  mux_4to1 #(.N(N)) u_mux (
    .sel (sel),
    .a   (data_a),
    .b   (data_b),
    .c   (data_c),
    .d   (data_d),
    .y   (out_data)
  );

`ifdef RR_ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BURST);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  logic [CW-1:0] cnt;
  logic          others;
  logic          preempt;

  // In GRANT last_winner equals sel, so the picker skips the owner.
  assign others  = |(req & ~gnt);
  assign preempt = (cnt == CNT_MAX) && others;
  assign rearb   = (state == ST_IDLE) || !owner_req || preempt;

  // Consecutive-grant counter, saturating, cleared on any new owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!rearb) begin
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end
`else
  logic unused_burst;
  assign unused_burst = (MAX_BURST > 1);
  assign rearb = (state == ST_IDLE) || !owner_req;
`endif

  // Grant state: hold the owner, hand over with no bubble, or idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      gnt         <= 4'b0000;
      sel         <= REQ_A;
      last_winner <= LAST_RESET;
    end else if (rearb) begin
      if (any) begin
        state       <= ST_GRANT;
        gnt         <= onehot4(winner);
        sel         <= winner;
        last_winner <= winner;
      end else begin
        state <= ST_IDLE;
        gnt   <= 4'b0000;
      end
    end
  end

endmodule
